// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_ctrl
// Purpose  : Single-port initiator for an OpenRAM RW SRAM macro. It accepts
//            valid/ready client requests, launches them on the macro's
//            csb0/web0/addr0/din0 pins from flops, and returns read data with
//            a fixed 2-cycle latency. It can optionally sweep every word to
//            INIT_VALUE after reset before accepting traffic.
// Ports    : clk0, rst0         - clock shared with the macro, async reset
//            req_valid/req_ready/req_we/req_addr/req_wdata - client request
//            rsp_valid/rsp_rdata - read response (one-cycle pulse)
//            init_done           - sweep finished or skipped
//            csb0/web0/addr0/din0 (out), dout0 (in) - macro port
// Revision : 1.0 - initial release
// ============================================================================
module sram_port_ctrl #(
  parameter int unsigned              DATA_WIDTH    = 2,
  parameter int unsigned              ADDR_WIDTH    = 4,
  parameter int unsigned              INIT_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]    INIT_VALUE    = '0
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic                  INIT_EN     = (INIT_ON_RESET != 0);
  localparam state_t                RESET_STATE = INIT_EN ? ST_INIT : ST_RUN;
  // Highest macro address (depth = 1 << ADDR_WIDTH).
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   sweep_addr;
  // Set once the write to LAST_ADDR has been launched; the following edge
  // closes the sweep. Keeps the counter from ever wrapping.
  logic                    sweep_last;
  // rd_pipe[0]: read launched on the macro pins at the last edge.
  // rd_pipe[1]: macro has sampled that read; dout0 is valid until just
  //             after the next edge, so capture happens on that edge.
  logic [1:0]              rd_pipe;

  logic handshake;
  logic rd_issue;

  // req_ready is only ever high in RUN, so no state qualifier is needed.
  assign handshake = req_valid & req_ready;
  assign rd_issue  = handshake & ~req_we;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state      <= RESET_STATE;
      sweep_addr <= '0;
      sweep_last <= 1'b0;
      rd_pipe    <= 2'b00;
      csb0       <= 1'b1;
      web0       <= 1'b1;
      addr0      <= '0;
      din0       <= '0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      req_ready  <= ~INIT_EN;
      init_done  <= ~INIT_EN;
    end else begin
      // Read tracking runs independently of the state machine.
      rd_pipe   <= {rd_pipe[0], rd_issue};
      rsp_valid <= rd_pipe[1];
      if (rd_pipe[1]) begin
        rsp_rdata <= dout0;
      end

      case (state)
        ST_INIT: begin
          if (sweep_last) begin
            csb0      <= 1'b1;
            init_done <= 1'b1;
            req_ready <= 1'b1;
            state     <= ST_RUN;
          end else begin
            csb0  <= 1'b0;
            web0  <= 1'b0;
            addr0 <= sweep_addr;
            din0  <= INIT_VALUE;
            if (sweep_addr == LAST_ADDR) begin
              sweep_last <= 1'b1;
            end else begin
              sweep_addr <= sweep_addr + 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (handshake) begin
            csb0  <= 1'b0;
            web0  <= ~req_we;
            addr0 <= req_addr;
            // Reads leave din0 untouched to avoid needless pin toggling.
            if (req_we) begin
              din0 <= req_wdata;
            end
          end else begin
            csb0 <= 1'b1;
          end
        end

        default: begin
          state <= RESET_STATE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sram_port_ctrl.md
# sram_port_ctrl

Single-port initiator that drives the csb0/web0/addr0/din0/dout0 port of an OpenRAM-generated RW SRAM macro (default 16x2) from a valid/ready request interface. It serialises client reads and writes onto the macro pins, captures read data at the correct edge, and returns it with a fixed latency. After reset it can optionally sweep every word to a known value before accepting traffic. It sits between core logic and the SRAM macro instance.

## Interface

- DATA_WIDTH, 2, data word width; must match the macro.
- ADDR_WIDTH, 4, address width; depth = 1 << ADDR_WIDTH.
- INIT_ON_RESET, 1, 1 = write INIT_VALUE to every address after reset; 0 = skip the sweep.
- INIT_VALUE, 0, DATA_WIDTH-bit word written during the sweep.

- clk0  in  1  clock; shared with the macro's clk0.
- rst0  in  1  asynchronous active-high reset.
- req_valid  in  1  client request present.
- req_ready  out  1  controller accepts a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  DATA_WIDTH  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse: rsp_rdata holds read data.
- rsp_rdata  out  DATA_WIDTH  read data.
- init_done  out  1  sweep finished, or skipped.
- csb0  out  1  macro chip select, active low.
- web0  out  1  macro write enable, active low.
- addr0  out  ADDR_WIDTH  macro address.
- din0  out  DATA_WIDTH  macro write data.
- dout0  in  DATA_WIDTH  macro read data.

## Operation

- All macro pins are driven from flops updated on posedge clk0. The macro samples the values launched on the previous edge.
- States: INIT and RUN.
  - Reset enters INIT when INIT_ON_RESET=1, otherwise RUN.
- INIT:
  - req_ready=0.
  - Address counter runs 0..DEPTH-1, issuing one write per cycle: csb0=0, web0=0, addr0=counter, din0=INIT_VALUE.
  - After the write to DEPTH-1 is launched, the next edge sets csb0=1, init_done=1 and state RUN.
  - The counter does not wrap.
- RUN:
  - req_ready=1 every cycle, giving full throughput with no bubbles.
  - On handshake (req_valid & req_ready) at edge k: csb0=0, web0=!req_we, addr0=req_addr, din0=req_wdata.
    - If the request is a write, din0 takes req_wdata; for a read, din0 holds its previous value.
  - With no handshake: csb0=1; web0, addr0 and din0 hold their previous values.
- Read tracking:
  - A 2-stage shift register of read-issued flags follows each launched read.
  - At edge k+2, dout0 is registered into rsp_rdata and rsp_valid pulses high for one cycle.
  - Writes produce no response.
- The response path has no back-pressure. The client must accept rsp_valid in the cycle it is asserted.
- Responses return in issue order, one per read.
- Read-after-write to the same address in consecutive cycles returns the new data: the macro writes on the negedge before the read is sampled.

## Timing

- Reset values (applied asynchronously):
  - csb0=1, web0=1, addr0=0, din0=0.
  - rsp_valid=0, rsp_rdata=0.
  - req_ready=0 if INIT_ON_RESET=1, else 1.
  - init_done=!INIT_ON_RESET.
  - Read pipeline cleared.
- Read latency: handshake at edge k gives rsp_valid=1 after edge k+2. This is 2 cycles, constant.
- Capture happens on the rising edge itself. The macro invalidates dout0 only T_HOLD after that edge, so the capture is hazard-free.
- Sweep duration: DEPTH cycles of csb0=0, then init_done rises at edge DEPTH+1 after reset release. The default is 16 writes, with init_done rising at edge 17.
- Reset mid-operation:
  - In-flight reads are dropped with no rsp_valid.
  - csb0 returns to 1 immediately.
  - The sweep restarts at address 0.
- Reset deassertion is synchronised to clk0 by the integrator. The block only needs rst0 stable for the edge after release.

## Test plan

- Reset with INIT_ON_RESET=1 -> csb0=1 during reset; 16 writes of 0 to addresses 0..15 after release; init_done=1 and req_ready=1 at edge 17.
- Write 0b10 to address 5, then read address 5 on the next cycle -> rsp_valid exactly 2 cycles after the read handshake, rsp_rdata=0b10.
- Back-to-back reads of addresses 0..15 after writing data = addr[1:0] -> 16 consecutive rsp_valid pulses with no gaps, in order, with data = addr[1:0].
- Interleave write(3,0b01), read(3), write(3,0b11), read(3) in consecutive cycles -> responses 0b01 then 0b11.
- Assert rst0 one cycle after a read handshake -> no rsp_valid; csb0=1 asynchronously; the sweep restarts from address 0.
- INIT_ON_RESET=0 -> init_done=1 and req_ready=1 out of reset; no macro activity until the first request.
